// File: rtl/hearts_controller_if.sv
`default_nettype none
// ==========================================================================
// hearts_controller_if : event inputs and life/blink status of the player
// Rev 1.0
// ==========================================================================
interface hearts_controller_if;
   logic       frame_tick;
   logic       collision;
   logic       heart_pickup;
   logic       restart;
   logic [1:0] num_hearts;
   logic       invulnerable;
   logic       sprite_visible;
   logic       hit_pulse;
   logic       game_over;

   modport master (
      output frame_tick, collision, heart_pickup, restart,
      input  num_hearts, invulnerable, sprite_visible, hit_pulse, game_over
   );

   modport slave (
      input  frame_tick, collision, heart_pickup, restart,
      output num_hearts, invulnerable, sprite_visible, hit_pulse, game_over
   );
endinterface
`default_nettype wire

// File: rtl/hearts_controller.sv
`default_nettype none
// ==========================================================================
// hearts_controller : life counter, post-hit invulnerability blink, game over
// Rev 1.0
// ==========================================================================
module hearts_controller #(
   parameter int MAX_HEARTS    = 3,
   parameter int INVULN_FRAMES = 120,
   parameter int BLINK_FRAMES  = 8
) (
   input wire                 clk,
   input wire                 reset,
   hearts_controller_if.slave hc
);

   localparam int FW = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [1:0]    c_MAX_HEARTS = 2'(MAX_HEARTS);
   localparam logic [FW-1:0] c_FRAME_LAST = FW'(INVULN_FRAMES - 1);
   localparam logic [BW-1:0] c_BLINK_LAST = BW'(BLINK_FRAMES - 1);

   typedef enum logic [1:0] {
      ST_ALIVE     = 2'd0,
      ST_INVULN    = 2'd1,
      ST_GAME_OVER = 2'd2
   } state_t;

   state_t        r_state;
   logic [1:0]    r_num_hearts;
   logic          r_invulnerable;
   logic          r_sprite_visible;
   logic          r_hit_pulse;
   logic          r_game_over;
   logic [FW-1:0] r_frame_cnt;
   logic [BW-1:0] r_blink_cnt;
   logic          r_pickup_prev;

   logic          w_pickup_edge;
   logic [1:0]    w_inc_val;
   logic [1:0]    w_hit_val;

   assign w_pickup_edge = hc.heart_pickup & ~r_pickup_prev;
   assign w_inc_val     = (r_num_hearts >= c_MAX_HEARTS) ? c_MAX_HEARTS : r_num_hearts + 2'd1;
   // Hearts are >= 1 in ALIVE, so a hit with a same-cycle pickup nets out unchanged.
   assign w_hit_val     = w_pickup_edge ? r_num_hearts : r_num_hearts - 2'd1;

   always_ff @(posedge clk) begin
      if (!reset || hc.restart) begin
         r_state          <= ST_ALIVE;
         r_num_hearts     <= c_MAX_HEARTS;
         r_invulnerable   <= 1'b0;
         r_sprite_visible <= 1'b1;
         r_hit_pulse      <= 1'b0;
         r_game_over      <= 1'b0;
         r_frame_cnt      <= '0;
         r_blink_cnt      <= '0;
         r_pickup_prev    <= 1'b0;
      end else begin
         r_pickup_prev <= hc.heart_pickup;
         r_hit_pulse   <= 1'b0;
         case (r_state)
            ST_ALIVE: begin
               if (hc.collision) begin
                  r_num_hearts <= w_hit_val;
                  r_hit_pulse  <= 1'b1;
                  r_frame_cnt  <= '0;
                  r_blink_cnt  <= '0;
                  if (w_hit_val == 2'd0) begin
                     r_state     <= ST_GAME_OVER;
                     r_game_over <= 1'b1;
                  end else begin
                     r_state        <= ST_INVULN;
                     r_invulnerable <= 1'b1;
                  end
               end else if (w_pickup_edge) begin
                  r_num_hearts <= w_inc_val;
               end
            end
            ST_INVULN: begin
               if (w_pickup_edge) begin
                  r_num_hearts <= w_inc_val;
               end
               if (hc.frame_tick) begin
                  if (r_frame_cnt == c_FRAME_LAST) begin
                     r_state          <= ST_ALIVE;
                     r_invulnerable   <= 1'b0;
                     r_sprite_visible <= 1'b1;
                     r_frame_cnt      <= '0;
                     r_blink_cnt      <= '0;
                  end else begin
                     r_frame_cnt <= r_frame_cnt + FW'(1);
                     if (r_blink_cnt == c_BLINK_LAST) begin
                        r_blink_cnt      <= '0;
                        r_sprite_visible <= ~r_sprite_visible;
                     end else begin
                        r_blink_cnt <= r_blink_cnt + BW'(1);
                     end
                  end
               end
            end
            ST_GAME_OVER: begin
               r_num_hearts     <= 2'd0;
               r_game_over      <= 1'b1;
               r_invulnerable   <= 1'b0;
               r_sprite_visible <= 1'b1;
            end
            default: r_state <= ST_ALIVE;
         endcase
      end
   end

   assign hc.num_hearts     = r_num_hearts;
   assign hc.invulnerable   = r_invulnerable;
   assign hc.sprite_visible = r_sprite_visible;
   assign hc.hit_pulse      = r_hit_pulse;
   assign hc.game_over      = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_hearts_controller.sv
`default_nettype none
// ==========================================================================
// tb_hearts_controller : directed vector table plus multi-cycle sequences
// Rev 1.0
// ==========================================================================
module tb_hearts_controller;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   hearts_controller_if hc();

   hearts_controller #(
      .MAX_HEARTS   (3),
      .INVULN_FRAMES(120),
      .BLINK_FRAMES (8)
   ) dut (
      .clk  (clk),
      .reset(rst_n),
      .hc   (hc.slave)
   );

   typedef struct {
      string      name;
      logic       col;
      logic       pick;
      logic       tick;
      logic       rs;
      logic [1:0] hearts;
      logic       inv;
      logic       vis;
      logic       hit;
      logic       go;
   } vec_t;

   vec_t tbl[10];

   task automatic cyc(input logic col, input logic pick, input logic tick, input logic rs);
      @(negedge clk);
      hc.collision    = col;
      hc.heart_pickup = pick;
      hc.frame_tick   = tick;
      hc.restart      = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Packed compare order: {hearts[1:0], invulnerable, sprite_visible, hit_pulse, game_over}
   task automatic chk_all(input string nm, input logic [1:0] h, input logic inv,
                          input logic vis, input logic hit, input logic go);
      chk(nm, {26'd0, hc.num_hearts, hc.invulnerable, hc.sprite_visible, hc.hit_pulse, hc.game_over},
          {26'd0, h, inv, vis, hit, go});
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      int hits;
      hc.collision    = 1'b0;
      hc.heart_pickup = 1'b0;
      hc.frame_tick   = 1'b0;
      hc.restart      = 1'b0;

      tbl[0] = '{"idle",          0,0,0,0, 2'd3, 0,1,0,0};
      tbl[1] = '{"first_hit",     1,0,0,0, 2'd2, 1,1,1,0};
      tbl[2] = '{"hold_col_a",    1,0,0,0, 2'd2, 1,1,0,0};
      tbl[3] = '{"hold_col_b",    1,0,1,0, 2'd2, 1,1,0,0};
      tbl[4] = '{"pick_in_inv",   0,1,0,0, 2'd3, 1,1,0,0};
      tbl[5] = '{"pick_held",     0,1,0,0, 2'd3, 1,1,0,0};
      tbl[6] = '{"pick_low",      0,0,0,0, 2'd3, 1,1,0,0};
      tbl[7] = '{"pick_sat",      0,1,0,0, 2'd3, 1,1,0,0};
      tbl[8] = '{"restart_col",   1,0,0,1, 2'd3, 0,1,0,0};
      tbl[9] = '{"hit_after_rst", 1,0,0,0, 2'd2, 1,1,1,0};

      // Reset held two cycles, then released
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_all("reset_state", 2'd3, 0, 1, 0, 0);
      rst_n = 1'b1;
      cyc(0, 0, 0, 0);
      chk_all("reset_idle", 2'd3, 0, 1, 0, 0);

      foreach (tbl[i]) begin
         cyc(tbl[i].col, tbl[i].pick, tbl[i].tick, tbl[i].rs);
         chk_all(tbl[i].name, tbl[i].hearts, tbl[i].inv, tbl[i].vis, tbl[i].hit, tbl[i].go);
      end

      // Collision held for 50 cycles yields exactly one hit
      cyc(0, 0, 0, 1);
      chk_all("restart_clean", 2'd3, 0, 1, 0, 0);
      hits = 0;
      for (int i = 0; i < 50; i++) begin
         cyc(1, 0, 0, 0);
         if (hc.hit_pulse) hits++;
         if (i == 0) chk_all("long_col_first", 2'd2, 1, 1, 1, 0);
      end
      chk("long_col_hits", hits, 1);
      chk("long_col_hearts", {30'd0, hc.num_hearts}, 2);

      // Invulnerability window: blink every 8 ticks, exit on the 120th tick
      for (int k = 1; k <= 120; k++) begin
         logic exp_inv, exp_vis;
         cyc(0, 0, 1, 0);
         exp_inv = (k < 120);
         exp_vis = (k == 120) ? 1'b1 : (((k / 8) % 2) == 0);
         chk($sformatf("blink_tick_%0d", k), {30'd0, hc.invulnerable, hc.sprite_visible},
             {30'd0, exp_inv, exp_vis});
      end
      chk("after_window_hearts", {30'd0, hc.num_hearts}, 2);

      // Pickup level held 10 cycles gives a single increment; saturates at 3
      for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
      chk_all("pickup_held", 2'd3, 0, 1, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      chk_all("pickup_saturate", 2'd3, 0, 1, 0, 0);
      cyc(0, 0, 0, 0);

      // Down to one heart, collision held across window exit (no grace), fatal hit
      cyc(1, 0, 0, 0);
      chk_all("hit_to_2", 2'd2, 1, 1, 1, 0);
      run_ticks(120);
      cyc(1, 0, 0, 0);
      chk_all("hit_to_1", 2'd1, 1, 1, 1, 0);
      run_ticks(119);
      cyc(1, 0, 1, 0);
      chk_all("exit_with_col", 2'd1, 0, 1, 0, 0);
      cyc(1, 0, 0, 0);
      chk_all("fatal_hit", 2'd0, 0, 1, 1, 1);
      cyc(1, 1, 1, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      chk_all("game_over_hold", 2'd0, 0, 1, 0, 1);
      cyc(0, 0, 0, 1);
      chk_all("restart_from_go", 2'd3, 0, 1, 0, 0);

      // Simultaneous collision and pickup edge at one heart
      cyc(1, 0, 0, 0);
      run_ticks(120);
      cyc(1, 0, 0, 0);
      chk_all("sim_setup_1", 2'd1, 1, 1, 1, 0);
      run_ticks(120);
      cyc(1, 1, 0, 0);
      chk_all("col_pick_same", 2'd1, 1, 1, 1, 0);
      cyc(0, 0, 0, 0);
      chk_all("col_pick_after", 2'd1, 1, 1, 0, 0);

      // Restart coincident with collision at two hearts
      cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 0);
      run_ticks(120);
      chk_all("rs_col_setup", 2'd2, 0, 1, 0, 0);
      cyc(1, 0, 0, 1);
      chk_all("restart_beats_hit", 2'd3, 0, 1, 0, 0);
      cyc(0, 0, 0, 0);
      chk_all("restart_beats_hit_2", 2'd3, 0, 1, 0, 0);

      // Reset mid-window aborts invulnerability
      cyc(1, 0, 0, 0);
      run_ticks(10);
      chk_all("mid_win_tick10", 2'd2, 1, 0, 0, 0);
      run_ticks(10);
      chk_all("mid_win_tick20", 2'd2, 1, 1, 0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk_all("reset_mid_win", 2'd3, 0, 1, 0, 0);
      rst_n = 1'b1;
      cyc(0, 0, 1, 0);
      chk_all("after_reset_mid", 2'd3, 0, 1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
